// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select encodings used by the decoder and the
// fetch stage, reset/NOP constants and the fetch state encoding.
package cpu_pkg;

    // PC-select encodings produced by the control decoder
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;

    // Default PC after reset and the word used for an empty IF/ID slot
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] INST_NOP_WORD    = 32'h0000_0000;

    // FETCH: normal operation; DISCARD: waiting out a stale request after a redirect
    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    // Force a target onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: catches a word fetched while IF/ID is stalled so the
// memory handshake never has to be retracted.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc_plus4,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4
);

    logic        valid_reg;
    logic [31:0] inst_reg;
    logic [31:0] pc_plus4_reg;

    // Clear wins, then load (a simultaneous unload+load refills the entry), then unload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            inst_reg     <= INST_NOP_WORD;
            pc_plus4_reg <= 32'h0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg    <= 1'b1;
            inst_reg     <= load_inst;
            pc_plus4_reg <= load_pc_plus4;
        end else if (unload) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid    = valid_reg;
    assign inst     = inst_reg;
    assign pc_plus4 = pc_plus4_reg;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, the instruction-memory handshake,
// the IF/ID register and redirect handling (branch, j/jal, jr/jalr).
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] INST_NOP = INST_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic [5:0]  if_id_opcode,
    output logic [5:0]  if_id_funct
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  npc_hold_reg, npc_hold_next;
    logic         if_id_valid_reg, if_id_valid_next;
    logic [31:0]  if_id_inst_reg, if_id_inst_next;
    logic [31:0]  if_id_pc_plus4_reg, if_id_pc_plus4_next;

    logic         skid_valid;
    logic [31:0]  skid_inst;
    logic [31:0]  skid_pc_plus4;
    logic         skid_load, skid_unload, skid_clear;

    logic         redirect;
    logic [31:0]  npc;
    logic         if_id_open;
    logic         xfer;
    logic [31:0]  pc_plus4;

    assign pc_plus4   = pc_reg + 32'd4;
    assign if_id_open = !if_id_valid_reg || !stall;
    assign xfer       = imem_req && imem_ready;

    // Redirect selection: EX branch first (even under stall), then ID jumps
    always_comb begin
        redirect = 1'b0;
        npc      = pc_plus4;
        if (branch_taken) begin
            redirect = 1'b1;
            npc      = word_align(branch_target);
        end else if (if_id_valid_reg && !stall && pc_src == PCSRC_J) begin
            redirect = 1'b1;
            npc      = {if_id_pc_plus4_reg[31:28], if_id_inst_reg[25:0], 2'b00};
        end else if (if_id_valid_reg && !stall && pc_src == PCSRC_JR) begin
            redirect = 1'b1;
            npc      = word_align(jr_target);
        end
    end

    // Request is held off only when the skid entry is occupied and IF/ID cannot move
    always_comb begin
        imem_req = 1'b0;
        case (state_reg)
            FETCH:   imem_req = rst_n && (!skid_valid || if_id_open);
            DISCARD: imem_req = rst_n;
            default: imem_req = 1'b0;
        endcase
    end

    // Next-state, PC and IF/ID update logic
    always_comb begin
        state_next          = state_reg;
        pc_next             = pc_reg;
        npc_hold_next       = npc_hold_reg;
        if_id_valid_next    = if_id_valid_reg;
        if_id_inst_next     = if_id_inst_reg;
        if_id_pc_plus4_next = if_id_pc_plus4_reg;
        skid_load           = 1'b0;
        skid_unload         = 1'b0;
        skid_clear          = 1'b0;

        case (state_reg)
            FETCH: begin
                if (redirect) begin
                    // Flush everything younger than the redirecting instruction
                    skid_clear       = 1'b1;
                    if_id_valid_next = 1'b0;
                    if_id_inst_next  = INST_NOP;
                    if (imem_req && !imem_ready) begin
                        // Request cannot be withdrawn: wait it out at the old address
                        state_next    = DISCARD;
                        npc_hold_next = npc;
                    end else begin
                        pc_next = npc;
                    end
                end else begin
                    if (if_id_open) begin
                        if (skid_valid) begin
                            if_id_valid_next    = 1'b1;
                            if_id_inst_next     = skid_inst;
                            if_id_pc_plus4_next = skid_pc_plus4;
                            skid_unload         = 1'b1;
                        end else if (xfer) begin
                            if_id_valid_next    = 1'b1;
                            if_id_inst_next     = imem_rdata;
                            if_id_pc_plus4_next = pc_plus4;
                        end else begin
                            if_id_valid_next = 1'b0;
                            if_id_inst_next  = INST_NOP;
                        end
                    end
                    if (xfer) begin
                        pc_next = pc_plus4;
                        // IF/ID is either held or being fed from the skid entry
                        if (!if_id_open || skid_valid) begin
                            skid_load = 1'b1;
                        end
                    end
                end
            end

            DISCARD: begin
                if (redirect) begin
                    npc_hold_next    = npc;
                    skid_clear       = 1'b1;
                    if_id_valid_next = 1'b0;
                    if_id_inst_next  = INST_NOP;
                end
                if (imem_ready) begin
                    state_next = FETCH;
                    pc_next    = redirect ? npc : npc_hold_reg;
                end
            end

            default: state_next = FETCH;
        endcase
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= FETCH;
            pc_reg             <= RESET_PC;
            npc_hold_reg       <= RESET_PC;
            if_id_valid_reg    <= 1'b0;
            if_id_inst_reg     <= INST_NOP;
            if_id_pc_plus4_reg <= 32'h0;
        end else begin
            state_reg          <= state_next;
            pc_reg             <= pc_next;
            npc_hold_reg       <= npc_hold_next;
            if_id_valid_reg    <= if_id_valid_next;
            if_id_inst_reg     <= if_id_inst_next;
            if_id_pc_plus4_reg <= if_id_pc_plus4_next;
        end
    end

    fetch_skid_buf u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (skid_load),
        .unload        (skid_unload),
        .clear         (skid_clear),
        .load_inst     (imem_rdata),
        .load_pc_plus4 (pc_plus4),
        .valid         (skid_valid),
        .inst          (skid_inst),
        .pc_plus4      (skid_pc_plus4)
    );

    assign imem_addr      = pc_reg;
    assign if_id_valid    = if_id_valid_reg;
    assign if_id_inst     = if_id_inst_reg;
    assign if_id_pc_plus4 = if_id_pc_plus4_reg;
    assign if_id_opcode   = if_id_inst_reg[31:26];
    assign if_id_funct    = if_id_inst_reg[5:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed steps followed by randomized traffic,
// checked against a transaction-level model of the fetch stream.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] jr_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic [5:0]  if_id_opcode;
    logic [5:0]  if_id_funct;

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(RST_PC), .INST_NOP(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jr_target(jr_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_opcode(if_id_opcode), .if_id_funct(if_id_funct)
    );

    // Memory returns the address as data, except one planted j 0x00400040
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_000C) return 32'h0810_0010;
        return a;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int cmps = 0;
    int errs = 0;

    // Model: instructions owed to IF/ID in program order, next address to fetch,
    // and whether a stale request is being waited out
    logic [31:0] q_inst[$];
    logic [31:0] q_pc4[$];
    logic [31:0] exp_fetch;
    logic [31:0] disc_npc;
    bit          disc;
    bit          prev_pend;
    logic [31:0] prev_addr;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_inst, obs_pc4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_inst.delete();
        q_pc4.delete();
        exp_fetch = RST_PC;
        disc_npc  = RST_PC;
        disc      = 1'b0;
        prev_pend = 1'b0;
        prev_addr = RST_PC;
    endtask

    // One cycle: drive inputs at the falling edge, check and advance the model,
    // then wait for the next falling edge (the rising edge happens in between)
    task automatic step(input logic rdy, input logic stl, input logic [1:0] ps,
                        input logic [31:0] jt, input logic bt, input logic [31:0] btg);
        logic        redir;
        logic        acc;
        logic [31:0] npc;
        logic [31:0] f_inst;
        logic [31:0] f_pc4;
        imem_ready    = rdy;
        stall         = stl;
        pc_src        = ps;
        jr_target     = jt;
        branch_taken  = bt;
        branch_target = btg;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = if_id_valid;
        obs_inst  = if_id_inst;
        obs_pc4   = if_id_pc_plus4;

        chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prev_pend) begin
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, (q_inst.size() > 0)});
        if (q_inst.size() > 0) begin
            chk("if_id_inst", if_id_inst, q_inst[0]);
            chk("if_id_pc4", if_id_pc_plus4, q_pc4[0]);
        end else begin
            chk("if_id_nop", if_id_inst, 32'h0);
        end
        chk("opcode", {26'd0, if_id_opcode}, {26'd0, if_id_inst[31:26]});
        chk("funct", {26'd0, if_id_funct}, {26'd0, if_id_inst[5:0]});
        if (disc) begin
            chk("req_disc", {31'd0, imem_req}, 32'd1);
        end else begin
            chk("req_fetch", {31'd0, imem_req}, {31'd0, !(stl && q_inst.size() == 2)});
            if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
        end

        acc   = imem_req && rdy;
        redir = 1'b0;
        npc   = 32'h0;
        if (q_inst.size() > 0) begin
            f_inst = q_inst[0];
            f_pc4  = q_pc4[0];
        end else begin
            f_inst = 32'h0;
            f_pc4  = 32'h0;
        end
        if (bt) begin
            redir = 1'b1;
            npc   = btg & 32'hFFFF_FFFC;
        end else if (q_inst.size() > 0 && !stl && ps == 2'b01) begin
            redir = 1'b1;
            npc   = {f_pc4[31:28], f_inst[25:0], 2'b00};
        end else if (q_inst.size() > 0 && !stl && ps == 2'b10) begin
            redir = 1'b1;
            npc   = jt & 32'hFFFF_FFFC;
        end

        if (redir) begin
            if (disc) begin
                if (acc) begin
                    disc      = 1'b0;
                    exp_fetch = npc;
                end else begin
                    disc_npc = npc;
                end
            end else if (imem_req && !rdy) begin
                disc     = 1'b1;
                disc_npc = npc;
            end else begin
                exp_fetch = npc;
            end
            q_inst.delete();
            q_pc4.delete();
        end else begin
            if (q_inst.size() > 0 && !stl) begin
                void'(q_inst.pop_front());
                void'(q_pc4.pop_front());
            end
            if (acc) begin
                if (disc) begin
                    disc      = 1'b0;
                    exp_fetch = disc_npc;
                end else begin
                    q_inst.push_back(mem_word(imem_addr));
                    q_pc4.push_back(imem_addr + 32'd4);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        prev_pend = imem_req && !rdy;
        prev_addr = imem_addr;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp1_a0", obs_addr, 32'h0040_0000);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp1_a1", obs_addr, 32'h0040_0004);
        chk("tp1_inst0", obs_inst, 32'h0040_0000);
        chk("tp1_pc4_0", obs_pc4, 32'h0040_0004);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp1_a2", obs_addr, 32'h0040_0008);
        step(1, 0, 2'b00, 0, 0, 0);

        // j 0x00400040 sitting in IF/ID
        step(1, 0, 2'b01, 0, 0, 0);
        chk("tp2_jinst", obs_inst, 32'h0810_0010);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp2_target", obs_addr, 32'h0040_0040);
        chk("tp2_bubble", {31'd0, obs_valid}, 32'd0);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp2_valid", {31'd0, obs_valid}, 32'd1);

        // Branch while a request to 0x00400008 is pending
        step(1, 0, 2'b00, 0, 1, 32'h0040_0008);
        step(0, 0, 2'b00, 0, 1, 32'h0040_0100);
        chk("tp3_hold0", obs_addr, 32'h0040_0008);
        step(0, 0, 2'b00, 0, 1, 32'h0040_0100);
        chk("tp3_hold1", obs_addr, 32'h0040_0008);
        step(0, 0, 2'b00, 0, 1, 32'h0040_0100);
        chk("tp3_hold2", obs_addr, 32'h0040_0008);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp3_drop", obs_addr, 32'h0040_0008);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp3_target", obs_addr, 32'h0040_0100);
        step(1, 0, 2'b00, 0, 0, 0);

        // Stall for four cycles with memory always ready
        step(1, 1, 2'b00, 0, 0, 0);
        chk("tp4_req_first", {31'd0, obs_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2'b00, 0, 0, 0);
            chk("tp4_req_off", {31'd0, obs_req}, 32'd0);
        end
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp4_resume_req", {31'd0, obs_req}, 32'd1);
        chk("tp4_resume_addr", obs_addr, 32'h0040_010C);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp4_skid_word", obs_inst, 32'h0040_0108);

        // jr with a misaligned register value
        step(1, 0, 2'b10, 32'h0040_0203, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("tp5_jr", obs_addr, 32'h0040_0200);

        // PC wrap-around
        step(1, 0, 2'b00, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("wrap_last", obs_addr, 32'hFFFF_FFFC);
        step(1, 0, 2'b00, 0, 0, 0);
        chk("wrap_zero", obs_addr, 32'h0000_0000);
        step(1, 0, 2'b00, 0, 1, RST_PC);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rdy, r_stl, r_bt;
            logic [1:0]  r_ps;
            logic [31:0] r_jt, r_btg;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_ps  = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            r_bt  = ($urandom_range(0, 15) == 0);
            r_jt  = 32'h0040_0000 | ($urandom & 32'h0000_FFFF);
            r_btg = 32'h0040_0000 | ($urandom & 32'h0000_FFFF);
            step(r_rdy, r_stl, r_ps, r_jt, r_bt, r_btg);
        end

        // Reset asserted while waiting out a stale request
        step(1, 0, 2'b00, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0);
        step(0, 0, 2'b00, 0, 1, 32'h0040_0300);
        imem_ready   = 1'b0;
        branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
        chk("rst_mid_valid", {31'd0, if_id_valid}, 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(1, 0, 2'b00, 0, 0, 0);
        chk("rst_first_addr", obs_addr, RST_PC);
        chk("rst_first_req", {31'd0, obs_req}, 32'd1);
        step(1, 0, 2'b00, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
